// File: rtl/div_unit_pkg.sv
// Shared constants and types for the multi-cycle integer divider.
// Opcode values are decoded upstream into start_i/signed_i; listed here for reference.
// Also holds the FSM state encoding, the iteration count and an operand helper.
package div_unit_pkg;

  // ALU opcodes that select this unit (decoded outside the divider)
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  // One quotient bit per iteration, 32-bit operands
  localparam int DIV_ITER = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Magnitude of an operand; only treated as signed when the op is DIV.
  // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] abs_op(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Execute-stage handshake bundle between the pipeline and the divider.
// start_i is held while stalled; stall_o feeds the hazard unit directly.
// master = pipeline side, slave = divider side.
interface div_unit_if;
  logic        start_i;
  logic        signed_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        annul_i;
  logic        stall_o;
  logic        ready_o;
  logic [63:0] result_o;

  modport master (
    output start_i, signed_i, a_i, b_i, annul_i,
    input  stall_o, ready_o, result_o
  );

  modport slave (
    input  start_i, signed_i, a_i, b_i, annul_i,
    output stall_o, ready_o, result_o
  );
endinterface

// File: rtl/div_unit_iter.sv
// One restoring-division step: shift the 64-bit partial remainder left, trial-subtract {div,0}.
// Latency: combinational, no state.
// Backpressure: none; the caller decides when to register the step.
module div_iter (
  input  logic [63:0] i_rem,
  input  logic [31:0] i_div,
  output logic [63:0] o_rem,
  output logic        o_q
);

  // 65 bits so the bit shifted out of the top still takes part in the compare
  logic [64:0] w_sh;
  logic        w_ge;
  logic [31:0] w_trial;

  assign w_sh    = {i_rem, 1'b0};
  assign w_ge    = (w_sh[64:32] >= {1'b0, i_div});
  // The kept difference is always below the divisor, so 32 bits are enough
  assign w_trial = w_sh[63:32] - i_div;

  assign o_q   = w_ge;
  // Bit 0 is left at zero; the caller ORs the quotient bit in
  assign o_rem = {(w_ge ? w_trial : w_sh[63:32]), w_sh[31:0]};

endmodule

// File: rtl/div_unit.sv
// 32-bit DIV/DIVU, restoring algorithm on magnitudes, sign fix-up on completion.
// Latency: 33 stall cycles, result in cycle 33 (1 stall cycle for b==0 with DIV_ZERO_FAST_EN).
// Backpressure: stall_o holds the pipeline while busy; annul_i/rst abort to IDLE immediately.
module div_unit
  import div_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  div_state_t  r_state;
  div_state_t  w_state_nxt;
  logic [5:0]  r_cnt;
  logic [63:0] r_rem;
  logic [31:0] r_b;
  logic [31:0] r_a_raw;
  logic        r_q_neg;
  logic        r_r_neg;
  logic        r_b_zero;
  logic [63:0] r_result;

  logic        w_start;
  logic        w_last;
  logic        w_kill;
  logic        w_b_zero_in;
  logic [63:0] w_iter_rem;
  logic        w_iter_q;
  logic [63:0] w_rem_step;
  logic [31:0] w_hi;
  logic [31:0] w_lo;
  logic [63:0] w_final;

  assign w_kill      = bus.annul_i | rst;
  assign w_start     = (r_state == DIV_IDLE) & bus.start_i & ~w_kill;
  assign w_last      = (r_state == DIV_BUSY) & (r_cnt == 6'(DIV_ITER - 1));
  assign w_b_zero_in = (bus.b_i == 32'd0);

  div_iter u_iter (
    .i_rem (r_rem),
    .i_div (r_b),
    .o_rem (w_iter_rem),
    .o_q   (w_iter_q)
  );

  assign w_rem_step = w_iter_rem | {63'd0, w_iter_q};

  // Sign fix-up on the final step; a zero divisor bypasses it with the fixed hi/lo pattern
  assign w_hi    = r_r_neg ? (~w_rem_step[63:32] + 32'd1) : w_rem_step[63:32];
  assign w_lo    = r_q_neg ? (~w_rem_step[31:0] + 32'd1) : w_rem_step[31:0];
  assign w_final = r_b_zero ? {r_a_raw, 32'hFFFF_FFFF} : {w_hi, w_lo};

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= DIV_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state; DONE always returns to IDLE so the held start_i cannot retrigger
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DIV_IDLE: begin
        if (w_start) begin
`ifdef DIV_ZERO_FAST_EN
          w_state_nxt = w_b_zero_in ? DIV_DONE : DIV_BUSY;
`else
          w_state_nxt = DIV_BUSY;
`endif
        end
      end
      DIV_BUSY: if (w_last) w_state_nxt = DIV_DONE;
      DIV_DONE: w_state_nxt = DIV_IDLE;
      default:  w_state_nxt = DIV_IDLE;
    endcase
    if (bus.annul_i) w_state_nxt = DIV_IDLE;
  end

  // Operand latch, iteration and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= 6'd0;
      r_rem    <= 64'd0;
      r_b      <= 32'd0;
      r_a_raw  <= 32'd0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_b_zero <= 1'b0;
      r_result <= 64'd0;
    end else begin
      if (w_start) begin
        r_cnt    <= 6'd0;
        r_rem    <= {32'd0, abs_op(bus.a_i, bus.signed_i)};
        r_b      <= abs_op(bus.b_i, bus.signed_i);
        r_a_raw  <= bus.a_i;
        r_q_neg  <= bus.signed_i & (bus.a_i[31] ^ bus.b_i[31]);
        r_r_neg  <= bus.signed_i & bus.a_i[31];
        r_b_zero <= w_b_zero_in;
`ifdef DIV_ZERO_FAST_EN
        if (w_b_zero_in) r_result <= {bus.a_i, 32'hFFFF_FFFF};
`endif
      end
      if ((r_state == DIV_BUSY) && !bus.annul_i) begin
        r_rem <= w_rem_step;
        r_cnt <= r_cnt + 6'd1;
        if (w_last) r_result <= w_final;
      end
    end
  end

  assign bus.stall_o  = (w_start | (r_state == DIV_BUSY)) & ~w_kill;
  assign bus.ready_o  = (r_state == DIV_DONE) & ~w_kill;
  assign bus.result_o = r_result;

endmodule
